wrr_sched: RTL and testbench
============================

# wrr_sched

Four-requester weighted round-robin scheduler with a programmable per-requester time quantum. It sits in front of the shared resource that the round-robin arbiter guards. It lets software give each requester a different hold time instead of one fixed quantum, and it releases the resource early when the holder drops its request. It has one clock, registered one-hot grants, and a small configuration write port.

## Interface
- `QW`, default 8: quantum/counter width in bits.
- `DEFAULT_Q`, default 10: reset quantum for every requester, in cycles (100 ns at a 10 ns clock).
- `clk  in  1`: clock. All logic is on the rising edge.
- `rst  in  1`: reset. Synchronous, active-low.
- `req0..req3  in  1 each`: request lines. Level-sensitive.
- `cfg_we  in  1`: quantum write strobe.
- `cfg_idx  in  2`: requester index to write.
- `cfg_q  in  QW`: quantum value in cycles. 0 masks (disables) that requester.
- `gnt0..gnt3  out  1 each`: one-hot grant, registered.
- `gnt_id  out  2`: index of the current holder. Valid only while `busy`=1.
- `busy  out  1`: 1 when any grant is asserted.

## Operation
- State is `IDLE` or `GRANT`. The block also holds a down-counter `cnt[QW-1:0]`, a last-holder pointer `last[1:0]` and four quantum registers `q0..q3`.
- Eligible requester `i`: `req_i`=1 and `q_i`≠0.
- Priority order starts at `last+1` mod 4 and wraps, so `last` itself is checked last.
- `IDLE` → `GRANT`: taken at any edge with at least one eligible requester.
  - Assert the winner's `gnt`.
  - Set `gnt_id` = winner and `last` = winner.
  - Load `cnt` = `q_winner` − 1.
- `GRANT`, holder still requesting and `cnt`≠0: decrement `cnt` and hold the grant.
- Grant ends at an edge where either:
  - the holder's `req` is 0 (early release), or
  - `cnt`=0 (quantum expired).
- At that same edge, re-arbitrate among eligible requesters using the updated `last`:
  - If a winner exists, grant it with no idle cycle between grants.
  - The previous holder may win again only if it is the sole eligible requester. It then receives a fresh quantum.
  - If there is no winner, go to `IDLE` and drive all `gnt*`=0.
- Config write: at an edge with `cfg_we`=1, `q[cfg_idx]` ← `cfg_q`.
  - A write to the current holder does not change the running `cnt`. The new value applies from that requester's next grant.
  - Writing 0 to the current holder does not revoke its grant. The grant ends by release or expiry.
- Reset (`rst`=0 at an edge):
  - State `IDLE`, all `gnt*`=0, `gnt_id`=0, `busy`=0, `cnt`=0.
  - `last`=3, so requester 0 has top priority first.
  - `q0..q3`=`DEFAULT_Q`.
  - Reset overrides a concurrent `cfg_we`.
  - Reset in the middle of a grant drops it at that edge.

## Timing
- Grant latency: request high before edge *t* → `gnt` visible after edge *t*, i.e. one cycle.
- A holder that keeps requesting sees its `gnt` high for exactly `q_i` consecutive cycles (`q_i`≥1).
- Early release: holder `req` low before edge *t* → its `gnt` is low after edge *t*, and the next grant is visible after the same edge.
- Only one `gnt*` is ever high. `busy` equals the OR of all `gnt*`, computed from registers.
- `cfg_q`=1 gives a single-cycle grant. `cfg_q`=2^QW−1 is the maximum hold.

## Configuration
- Macro: `WRR_LOCK_EN`.
- Defined:
  - Adds input `lock` (1 bit).
  - While `lock`=1 and the holder is still requesting, quantum expiry is suppressed: `cnt` stays at 0 and the grant is held.
  - Early release on `req` low still applies.
  - Expiry resumes at the first edge where `lock`=0 and `cnt`=0.
- Undefined: the `lock` port is absent and every grant expires purely on quantum.

## Test plan
- Reset defaults, `req0`=`req1`=1 held for 40 cycles → alternating grants `gnt0` 10, `gnt1` 10, `gnt0` 10, `gnt1` 10. `gnt0` is first, one cycle after release of reset.
- Write q0=3, q2=6; hold `req0`, `req1`, `req2` → repeating pattern `gnt0`×3, `gnt1`×10, `gnt2`×6 with no gap cycles.
- `req0` alone, dropped after 4 cycles of grant, with `req3` high → `gnt0` for 4 cycles, then `gnt3` immediately after. `busy` stays 1 throughout.
- Write q1=0; `req1`=`req2`=1 → only `gnt2` is ever asserted. Rewrite q1=5 mid-grant → `gnt1` for 5 cycles after `gnt2` completes its 10.
- Assert `rst`=0 during a 10-cycle `gnt2` at cycle 4 → all `gnt*`=0 and `busy`=0 after that edge. After reset, with `req0`=`req2`=1, `gnt0` is granted first.
- With `WRR_LOCK_EN`: `lock`=1 during `gnt0`, q0=3 → `gnt0` held past 3 cycles. Drop `lock` at cycle 8 → `gnt0` ends at that edge and the next requester is granted.

Source files
------------

// File: rtl/wrr_sched.sv
// wrr_sched: four-requester weighted round-robin scheduler with a programmable per-requester quantum.
// Optional feature macro WRR_LOCK_EN adds a `lock` input that holds the current grant past quantum expiry.
module wrr_sched #(
    parameter int unsigned QW        = 8,
    parameter int unsigned DEFAULT_Q = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          req2,
    input  logic          req3,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_idx,
    input  logic [QW-1:0] cfg_q,
`ifdef WRR_LOCK_EN
    input  logic          lock,
`endif
    output logic          gnt0,
    output logic          gnt1,
    output logic          gnt2,
    output logic          gnt3,
    output logic [1:0]    gnt_id,
    output logic          busy
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_q [4];
    logic [QW-1:0] r_cnt;
    logic [1:0]    r_last;
    logic [1:0]    r_gnt_id;
    logic [3:0]    r_gnt;

    logic [3:0]    w_req;
    logic [3:0]    w_elig;
    logic [1:0]    w_scan;
    logic [1:0]    w_win;
    logic          w_win_vld;
    logic          w_hold_req;
    logic          w_expire;
    logic          w_end;

    assign w_req = {req3, req2, req1, req0};

    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_elig[i] = w_req[i] && (r_q[i] != '0);
        end
    end

    // Scan starts just after r_last, so the previous holder is only picked when nobody else is eligible.
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = r_last;
        w_scan    = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_scan = r_last + 2'(k);
            if (!w_win_vld && w_elig[w_scan]) begin
                w_win_vld = 1'b1;
                w_win     = w_scan;
            end
        end
    end

    assign w_hold_req = w_req[r_gnt_id];
`ifdef WRR_LOCK_EN
    assign w_expire   = (r_cnt == '0) && !lock;
`else
    assign w_expire   = (r_cnt == '0);
`endif
    assign w_end      = !w_hold_req || w_expire;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_cnt    <= '0;
            r_last   <= 2'd3;
            for (int unsigned i = 0; i < 4; i++) begin
                r_q[i] <= QW'(DEFAULT_Q);
            end
        end else begin
            if (cfg_we) begin
                r_q[cfg_idx] <= cfg_q;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_state  <= S_GRANT;
                        r_gnt    <= 4'b0001 << w_win;
                        r_gnt_id <= w_win;
                        r_last   <= w_win;
                        r_cnt    <= r_q[w_win] - 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!w_end) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end else if (w_win_vld) begin
                        r_gnt    <= 4'b0001 << w_win;
                        r_gnt_id <= w_win;
                        r_last   <= w_win;
                        r_cnt    <= r_q[w_win] - 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt0   = r_gnt[0];
    assign gnt1   = r_gnt[1];
    assign gnt2   = r_gnt[2];
    assign gnt3   = r_gnt[3];
    assign gnt_id = r_gnt_id;
    assign busy   = |r_gnt;

endmodule

// File: tb/tb_wrr_sched.sv
// Self-checking bench for wrr_sched: directed scenarios plus random traffic against a cycle-level reference model.
// Define WRR_LOCK_EN for both files to exercise the lock feature.
module tb_wrr_sched;

    localparam int unsigned QW        = 8;
    localparam int unsigned DEFAULT_Q = 10;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic [3:0]    req     = '0;
    logic          cfg_we  = 1'b0;
    logic [1:0]    cfg_idx = '0;
    logic [QW-1:0] cfg_q   = '0;
    logic          lock    = 1'b0;
    logic          gnt0, gnt1, gnt2, gnt3;
    logic [1:0]    gnt_id;
    logic          busy;

    wrr_sched #(.QW(QW), .DEFAULT_Q(DEFAULT_Q)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req[0]),
        .req1    (req[1]),
        .req2    (req[2]),
        .req3    (req[3]),
        .cfg_we  (cfg_we),
        .cfg_idx (cfg_idx),
        .cfg_q   (cfg_q),
`ifdef WRR_LOCK_EN
        .lock    (lock),
`endif
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt2    (gnt2),
        .gnt3    (gnt3),
        .gnt_id  (gnt_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: holder (-1 = none), cycles of grant still to show, rotation pointer, quanta.
    int m_q [4];
    int m_holder = -1;
    int m_left   = 0;
    int m_last   = 3;

    function automatic int pick();
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (req[i] && m_q[i] != 0) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int  w;
        bit  done;
        if (!rst) begin
            m_holder = -1;
            m_left   = 0;
            m_last   = 3;
            for (int i = 0; i < 4; i++) m_q[i] = DEFAULT_Q;
        end else begin
            w = pick();
            if (m_holder < 0) begin
                if (w >= 0) begin
                    m_holder = w; m_last = w; m_left = m_q[w];
                end
            end else begin
                done = !req[m_holder] || (m_left == 1 && !lock);
                if (!done) begin
                    if (m_left > 1) m_left--;
                end else if (w >= 0) begin
                    m_holder = w; m_last = w; m_left = m_q[w];
                end else begin
                    m_holder = -1;
                end
            end
            if (cfg_we) m_q[cfg_idx] = int'(cfg_q);
        end
    endtask

    // Grant run tracker: each finished run is stored as id*1000 + length.
    int runs [$];
    int cur_id  = -1;
    int cur_len = 0;

    task automatic clear_runs();
        runs.delete();
        cur_id  = -1;
        cur_len = 0;
    endtask

    task automatic cycle();
        logic [3:0] v;
        int         id;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        v = {gnt3, gnt2, gnt1, gnt0};
        chk("gnt", 32'(v), (m_holder >= 0) ? 32'(1 << m_holder) : 32'd0);
        chk("busy", 32'(busy), (m_holder >= 0) ? 32'd1 : 32'd0);
        if (m_holder >= 0) chk("gnt_id", 32'(gnt_id), 32'(m_holder));
        id = -1;
        for (int i = 0; i < 4; i++) if (v[i]) id = i;
        if (id != cur_id) begin
            if (cur_id >= 0) runs.push_back(cur_id * 1000 + cur_len);
            cur_id  = id;
            cur_len = 1;
        end else begin
            cur_len++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        req    = '0;
        cfg_we = 1'b0;
        lock   = 1'b0;
        run(2);
        rst = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [QW-1:0] val);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_q   = val;
        cycle();
        cfg_we  = 1'b0;
    endtask

    task automatic check_runs(input string tag, input int exp [$]);
        for (int k = 0; k < exp.size(); k++) begin
            chk($sformatf("%s_run%0d", tag, k), (runs.size() > k) ? 32'(runs[k]) : 32'hffffffff, 32'(exp[k]));
        end
    endtask

    initial begin
        int r;
        // Two requesters alternate on the default quantum, requester 0 first.
        do_reset();
        clear_runs();
        req = 4'b0011;
        run(43);
        check_runs("alt", '{10, 1010, 10, 1010});

        // Weighted three-way rotation with no gap cycles.
        do_reset();
        cfg_write(2'd0, 8'd3);
        cfg_write(2'd2, 8'd6);
        clear_runs();
        req = 4'b0111;
        run(45);
        check_runs("wrr", '{3, 1010, 2006, 3, 1010, 2006});

        // Early release hands over to requester 3 with no idle cycle.
        do_reset();
        req = 4'b1001;
        run(4);
        req = 4'b1000;
        run(4);

        // Masked requester never wins; re-enabling it mid-grant takes effect after the current holder.
        do_reset();
        cfg_write(2'd1, 8'd0);
        req = 4'b0110;
        run(4);
        cfg_write(2'd1, 8'd5);
        run(20);

        // Reset in the middle of a grant drops it; requester 0 wins first afterwards.
        do_reset();
        req = 4'b0100;
        run(4);
        rst = 1'b0;
        run(1);
        rst = 1'b1;
        req = 4'b0101;
        run(6);

        // Single-cycle quantum and maximum quantum.
        do_reset();
        cfg_write(2'd3, 8'd1);
        cfg_write(2'd1, 8'hff);
        req = 4'b1010;
        run(270);

`ifdef WRR_LOCK_EN
        // Lock holds requester 0 past its quantum until lock drops.
        do_reset();
        cfg_write(2'd0, 8'd3);
        req  = 4'b0011;
        lock = 1'b1;
        run(8);
        lock = 1'b0;
        run(4);
`endif

        // Random traffic, configuration writes and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
            cfg_we = ($urandom_range(0, 19) == 0);
            cfg_idx = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 7));
            if (r == 7) cfg_q = ($urandom_range(0, 9) == 0) ? 8'hff : 8'd4;
            else cfg_q = 8'(r);
`ifdef WRR_LOCK_EN
            if ($urandom_range(0, 3) == 0) lock = ~lock;
`endif
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
